long_wb_arb: RTL and testbench
==============================

Name: long_wb_arb

Overview:
- Writeback/commit arbiter for long-latency units (MUL, DIV, LSU load path). They share the single long-instruction writeback port to the register file, and the commit-ID release port into the hazard detection unit.
- Each requester has a 1-entry holding register. Held entries are granted round-robin whenever the short-pipe (ALU) writeback is not using the register-file port.
- Each grant drives one register write plus a one-cycle commit pulse carrying the instruction's commit ID.

Parameters:
- NUM_REQ, 3, number of long-latency requesters (2..8).
- REG_ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, writeback data width.
- COMMIT_ID_WIDTH, 2, commit ID width (matches hazard unit table of 4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  NUM_REQ  requester i has a completed result
- req_ready_o  out  NUM_REQ  holding slot i can accept this cycle
- req_rd_addr_i  in  NUM_REQ*REG_ADDR_WIDTH  destination register, packed, slot i at [i*W +: W]
- req_rd_we_i  in  NUM_REQ  result writes a register
- req_data_i  in  NUM_REQ*DATA_WIDTH  result data, packed
- req_commit_id_i  in  NUM_REQ*COMMIT_ID_WIDTH  commit ID assigned at issue, packed
- short_wb_valid_i  in  1  ALU writeback owns the register-file port this cycle
- wb_we_o  out  1  register-file write enable
- wb_rd_addr_o  out  REG_ADDR_WIDTH  write address
- wb_data_o  out  DATA_WIDTH  write data
- commit_valid_o  out  1  long instruction retired (to hazard unit)
- commit_id_o  out  COMMIT_ID_WIDTH  ID being retired
- busy_o  out  1  any holding slot occupied

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high; all state clears on a `clk` edge with `rst`=1.
- Reset values:
  - all hold_valid=0, rr_ptr=0.
  - req_ready_o=all 1s, since readiness is combinational from cleared state.
  - wb_we_o=0, commit_valid_o=0, busy_o=0; wb_rd_addr_o, wb_data_o and commit_id_o=0.
- Reset mid-operation discards held results; no commit pulse is produced for them.
- Holding slots:
  - Slot i loads when req_valid_i[i] && req_ready_o[i].
  - req_ready_o[i] = ~hold_valid[i] | grant[i]. A same-cycle release-and-refill is legal.
- Arbitration (combinational, per cycle):
  - Candidates = hold_valid.
  - If short_wb_valid_i=1, there is no grant; all holds persist and nothing is dropped.
  - Otherwise grant the first candidate found searching from rr_ptr upward, wrapping at NUM_REQ-1 -> 0.
- Grant effects, in the same cycle as the grant; outputs are combinational from the held slot:
  - commit_valid_o=1, commit_id_o = held ID.
  - wb_we_o = held rd_we && held rd_addr != 0. x0 still commits, but with no write.
  - wb_rd_addr_o / wb_data_o = held values when a grant exists, else 0.
  - On the clock edge: hold_valid[g] clears unless refilled, and rr_ptr <= (g+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Latency: request accepted at edge N; earliest commit is in cycle N+1.
- Throughput:
  - At most one commit per cycle.
  - A requester presenting back-to-back results sustains 1/cycle only when it is alone.
  - Under contention, each waiting slot is granted within NUM_REQ cycles of port availability.
- busy_o = |hold_valid.
- Invariants:
  - commit_valid_o is never asserted while short_wb_valid_i=1.
  - At most one grant bit is set per cycle.

Optional Feature:
- Macro: LONG_WB_BYPASS_EN.
- Defined: adds a zero-latency bypass.
  - Condition: no slot is held, short_wb_valid_i=0, and exactly one req_valid_i bit is set.
  - Effect: that request is committed in the same cycle directly from its inputs, is not written into its slot, and rr_ptr advances past it.
- Undefined: every result passes through its holding slot (minimum latency 1).

Test Plan:
1. Single result: requester 1 presents rd=5, data=0xDEADBEEF, id=2 at cycle 1 -> cycle 2: wb_we_o=1, addr 5, data 0xDEADBEEF, commit_valid_o=1, commit_id_o=2; cycle 3 all idle. With LONG_WB_BYPASS_EN the same outputs appear in cycle 1.
2. Contention: all 3 slots loaded at cycle 1 with rr_ptr=0 -> commits from slots 0,1,2 in cycles 2,3,4; rr_ptr=0 after; req_ready_o for each slot returns high as it is granted.
3. Short-port conflict: slot 0 held, short_wb_valid_i=1 for cycles 2-4 -> no commit in cycles 2-4; commit in cycle 5 with data intact.
4. x0 destination: rd=0, rd_we=1, id=3 -> commit_valid_o=1 with commit_id_o=3 and wb_we_o=0.
5. Refill-on-grant: slot 2 held and granted at cycle 3 while a new req_valid_i[2] arrives -> req_ready_o[2]=1 in cycle 3 and the new result commits in cycle 4.
6. Reset mid-operation: two slots held, rst=1 for one edge -> busy_o=0, no commit pulse afterward, rr_ptr=0.

Source files
------------

// File: rtl/long_wb_arb.sv
// long_wb_arb: round-robin writeback/commit arbiter for long-latency units (MUL/DIV/LSU).
// Optional macro LONG_WB_BYPASS_EN adds a zero-latency bypass when every slot is empty.
module long_wb_arb #(
  parameter int NUM_REQ         = 3,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int COMMIT_ID_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   req_rd_addr_i,
  input  logic [NUM_REQ-1:0]                  req_rd_we_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data_i,
  input  logic [NUM_REQ*COMMIT_ID_WIDTH-1:0]  req_commit_id_i,
  input  logic                                short_wb_valid_i,
  output logic                                wb_we_o,
  output logic [REG_ADDR_WIDTH-1:0]           wb_rd_addr_o,
  output logic [DATA_WIDTH-1:0]               wb_data_o,
  output logic                                commit_valid_o,
  output logic [COMMIT_ID_WIDTH-1:0]          commit_id_o,
  output logic                                busy_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         r_hold_valid;
  logic [NUM_REQ-1:0]         r_hold_we;
  logic [REG_ADDR_WIDTH-1:0]  r_hold_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0]      r_hold_data [NUM_REQ];
  logic [COMMIT_ID_WIDTH-1:0] r_hold_id   [NUM_REQ];
  logic [PTR_W-1:0]           r_rr_ptr;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_bypass;
  logic [NUM_REQ-1:0] w_load;
  logic               w_found;
  logic [PTR_W-1:0]   w_sel;
  logic [PTR_W-1:0]   w_cand;
  logic [PTR_W-1:0]   w_next_ptr;

  always_comb begin
    w_grant  = '0;
    w_bypass = '0;
    w_found  = 1'b0;
    w_sel    = '0;
    w_cand   = '0;
    if (!short_wb_valid_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_cand = PTR_W'((32'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_found && r_hold_valid[w_cand]) begin
          w_grant[w_cand] = 1'b1;
          w_found         = 1'b1;
          w_sel           = w_cand;
        end
      end
    end
`ifdef LONG_WB_BYPASS_EN
    // Bypass only when no slot is held, so it can never compete with a held grant.
    if (!short_wb_valid_i && (r_hold_valid == '0) && $onehot(req_valid_i)) begin
      w_bypass = req_valid_i;
      for (int unsigned i = 0; i < NUM_REQ; i++)
        if (req_valid_i[i]) w_sel = PTR_W'(i);
    end
`endif

    wb_we_o        = 1'b0;
    wb_rd_addr_o   = '0;
    wb_data_o      = '0;
    commit_valid_o = 1'b0;
    commit_id_o    = '0;
    if (w_found) begin
      commit_valid_o = 1'b1;
      commit_id_o    = r_hold_id[w_sel];
      wb_we_o        = r_hold_we[w_sel] && (r_hold_addr[w_sel] != '0);
      wb_rd_addr_o   = r_hold_addr[w_sel];
      wb_data_o      = r_hold_data[w_sel];
    end else if (|w_bypass) begin
      commit_valid_o = 1'b1;
      commit_id_o    = req_commit_id_i[w_sel*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH];
      wb_rd_addr_o   = req_rd_addr_i[w_sel*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      wb_we_o        = req_rd_we_i[w_sel] && (wb_rd_addr_o != '0);
      wb_data_o      = req_data_i[w_sel*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_next_ptr  = (32'(w_sel) == NUM_REQ - 1) ? '0 : w_sel + 1'b1;
  assign req_ready_o = ~r_hold_valid | w_grant;
  assign w_load      = req_valid_i & req_ready_o & ~w_bypass;
  assign busy_o      = |r_hold_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= '0;
      r_rr_ptr     <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_load[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_we[i]    <= req_rd_we_i[i];
          r_hold_addr[i]  <= req_rd_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
          r_hold_data[i]  <= req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
          r_hold_id[i]    <= req_commit_id_i[i*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH];
        end else if (w_grant[i]) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
      if (commit_valid_o) r_rr_ptr <= w_next_ptr;
    end
  end

endmodule

// File: tb/tb_long_wb_arb.sv
// Scoreboard bench for long_wb_arb (default build): expected commits queued with their cycle.
module tb_long_wb_arb;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 2;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_we;
  logic [NR*DW-1:0] req_data;
  logic [NR*IW-1:0] req_id;
  logic             short_wb;
  logic             wb_we;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic             commit_valid;
  logic [IW-1:0]    commit_id;
  logic             busy;

  long_wb_arb #(.NUM_REQ(NR), .REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COMMIT_ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rd_addr_i(req_addr), .req_rd_we_i(req_we),
    .req_data_i(req_data), .req_commit_id_i(req_id),
    .short_wb_valid_i(short_wb),
    .wb_we_o(wb_we), .wb_rd_addr_o(wb_addr), .wb_data_o(wb_data),
    .commit_valid_o(commit_valid), .commit_id_o(commit_id), .busy_o(busy)
  );

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int s, input logic [AW-1:0] a, input logic we,
                      input logic [DW-1:0] d, input logic [IW-1:0] id);
    req_valid[s]        = 1'b1;
    req_addr[s*AW +: AW] = a;
    req_we[s]           = we;
    req_data[s*DW +: DW] = d;
    req_id[s*IW +: IW]   = id;
  endtask

  task automatic expect_commit(input int c, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [IW-1:0] id);
    exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.data = d; e.id = id;
    q.push_back(e);
  endtask

  // Every monitored cycle: commit either matches the queue front scheduled for now, or outputs are idle.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      logic ev;
      ev = 1'b0;
      if (q.size() != 0) ev = (q[0].cyc == cyc);
      chk("commit_valid", commit_valid, ev);
      if (short_wb) chk("no_commit_on_short", commit_valid, 1'b0);
      if (ev) begin
        e = q.pop_front();
        chk("wb_we", wb_we, e.we);
        chk("wb_addr", wb_addr, e.addr);
        chk("wb_data", wb_data, e.data);
        chk("commit_id", commit_id, e.id);
      end else begin
        chk("idle_we", wb_we, 1'b0);
        chk("idle_addr", wb_addr, '0);
        chk("idle_data", wb_data, '0);
        chk("idle_id", commit_id, '0);
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1; req_valid = '0; req_addr = '0; req_we = '0; req_data = '0; req_id = '0;
    short_wb = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 3'b111);
    chk("rst_busy", busy, 1'b0);

    // Single result through slot 1
    tick();
    load(1, 5'd5, 1'b1, 32'hDEADBEEF, 2'd2);
    expect_commit(cyc + 1, 1'b1, 5'd5, 32'hDEADBEEF, 2'd2);
    tick(); req_valid = '0;
    @(negedge clk);
    chk("t1_busy_hold", busy, 1'b1);
    tick(); tick();                         // rr_ptr now 2

    // Reset with two held slots; short port blocks the grant in the reset cycle
    load(0, 5'd1, 1'b1, 32'h1111, 2'd0);
    load(1, 5'd2, 1'b1, 32'h2222, 2'd1);
    tick(); req_valid = '0; rst = 1'b1; short_wb = 1'b1;
    tick(); rst = 1'b0; short_wb = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", req_ready, 3'b111);
    tick(); tick();

    // Contention: all slots in one cycle; pointer must restart at 0
    load(0, 5'd10, 1'b1, 32'hA0A0_0000, 2'd0);
    load(1, 5'd11, 1'b1, 32'hA1A1_1111, 2'd1);
    load(2, 5'd12, 1'b1, 32'hA2A2_2222, 2'd2);
    c = cyc;
    expect_commit(c + 1, 1'b1, 5'd10, 32'hA0A0_0000, 2'd0);
    expect_commit(c + 2, 1'b1, 5'd11, 32'hA1A1_1111, 2'd1);
    expect_commit(c + 3, 1'b1, 5'd12, 32'hA2A2_2222, 2'd2);
    tick(); req_valid = '0;
    @(negedge clk); chk("t2_ready_c1", req_ready, 3'b001);
    tick(); @(negedge clk); chk("t2_ready_c2", req_ready, 3'b011);
    tick(); @(negedge clk); chk("t2_ready_c3", req_ready, 3'b111);
    tick();

    // Slots 0 and 2 together with rr_ptr=0: 0 first
    load(0, 5'd3, 1'b1, 32'h0000_0A03, 2'd1);
    load(2, 5'd4, 1'b1, 32'h0000_0C04, 2'd3);
    expect_commit(cyc + 1, 1'b1, 5'd3, 32'h0000_0A03, 2'd1);
    expect_commit(cyc + 2, 1'b1, 5'd4, 32'h0000_0C04, 2'd3);
    tick(); req_valid = '0;
    tick(); tick();

    // Short-port conflict: slot 0 held for three blocked cycles
    load(0, 5'd9, 1'b1, 32'hCAFE_F00D, 2'd1);
    expect_commit(cyc + 4, 1'b1, 5'd9, 32'hCAFE_F00D, 2'd1);
    tick(); req_valid = '0; short_wb = 1'b1;
    @(negedge clk); chk("t3_busy", busy, 1'b1);
    tick(); tick();
    tick(); short_wb = 1'b0;
    tick(); tick();                         // rr_ptr now 1

    // Wrap: rr_ptr=1, slots 0 and 2 -> 2 first, then 0
    load(0, 5'd20, 1'b1, 32'h0000_0014, 2'd2);
    load(2, 5'd22, 1'b1, 32'h0000_0016, 2'd0);
    expect_commit(cyc + 1, 1'b1, 5'd22, 32'h0000_0016, 2'd0);
    expect_commit(cyc + 2, 1'b1, 5'd20, 32'h0000_0014, 2'd2);
    tick(); req_valid = '0;
    tick(); tick();

    // x0 destination commits without writing; then a non-writing result
    load(1, 5'd0, 1'b1, 32'h1234_5678, 2'd3);
    expect_commit(cyc + 1, 1'b0, 5'd0, 32'h1234_5678, 2'd3);
    tick(); req_valid = '0;
    tick();
    load(0, 5'd7, 1'b0, 32'h0BAD_0007, 2'd0);
    expect_commit(cyc + 1, 1'b0, 5'd7, 32'h0BAD_0007, 2'd0);
    tick(); req_valid = '0;
    tick();

    // Refill-on-grant of slot 2
    load(2, 5'd15, 1'b1, 32'h5555_0001, 2'd1);
    expect_commit(cyc + 1, 1'b1, 5'd15, 32'h5555_0001, 2'd1);
    expect_commit(cyc + 2, 1'b1, 5'd16, 32'h5555_0002, 2'd2);
    tick();
    load(2, 5'd16, 1'b1, 32'h5555_0002, 2'd2);
    @(negedge clk); chk("t5_ready_refill", req_ready[2], 1'b1);
    tick(); req_valid = '0;
    tick(); tick(); tick();

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
